// File: rtl/mul_32.sv
// Sequential signed multiplier: radix-2 shift-add on operand magnitudes,
// then a sign fix-up, with a start/busy/done handshake.
module mul_32 #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] P,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    ma_q, ma_d;
    logic            neg_q, neg_d;
    logic [2*N-1:0]  p_q, p_d;
    logic            done_q, done_d;
    logic [N:0]      sum;

    // |-2^(N-1)| wraps to 2^(N-1), which is correct as an unsigned magnitude.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x);
        return x[N-1] ? -x : x;
    endfunction

    function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] m, input logic neg);
        return neg ? -m : m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        ma_q  <= ma_d;
        neg_q <= neg_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        ma_d   = ma_q;
        neg_d  = neg_q;
        p_d    = p_q;
        done_d = 1'b0;
        sum    = {1'b0, acc_q[2*N-1:N]};
        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d = A[N-1] ^ B[N-1];
                    ma_d  = magnitude(A);
                    acc_d = {{N{1'b0}}, magnitude(B)};
                    cnt_d = CW'(N);
                end
            end
            CALC: begin
                // The carry out of the add becomes the new MSB of the shifted accumulator.
                if (acc_q[0]) sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, ma_q};
                acc_d = {sum, acc_q[N-1:1]};
                cnt_d = cnt_q - CW'(1);
            end
            FIX: begin
                p_d    = apply_sign(acc_q, neg_q);
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        P    = p_q;
    end

endmodule

// File: tb/tb_mul_32.sv
// Self-checking bench for mul_32: directed vector table, handshake and reset
// sequences, and back-to-back random products against a plain-arithmetic model.
module tb_mul_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [63:0] P;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    mul_32 dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B), .P(P), .busy(busy), .done(done));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (done && busy) begin
                errors++;
                $display("FAIL done_busy_overlap: got done=%0b busy=%0b expected not both high", done, busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and verifies latency, busy width, product and done width.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input string name);
        int n;
        int busy_cnt;
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        busy_cnt = busy ? 1 : 0;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (busy) busy_cnt++;
        end
        check({name, "_latency"}, 64'(n), 64'd33);
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({name, "_P"}, P, exp);
        tick();
        check({name, "_done_width"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] a0, b0, a1, b1;
        logic [63:0] p_hold;
        int p_changes;

        tbl[0] = '{32'd7,         32'd9,         64'h0000_0000_0000_003F};
        tbl[1] = '{32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1};
        tbl[2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'h0000_0000_0000_000F};
        tbl[3] = '{32'd0,         32'hFFFF_FFFB, 64'h0000_0000_0000_0000};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[5] = '{32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000};
        tbl[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};

        tick();
        tick();
        check("reset_P", P, 64'd0);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i));
        end

        // start held high with operands churning every cycle.
        a0 = 32'hFFFF_F123;
        b0 = 32'h0001_2345;
        A = a0;
        B = b0;
        start = 1'b1;
        tick();
        p_hold = P;
        p_changes = 0;
        n = 0;
        while (!done && n < 100) begin
            A = $urandom;
            B = $urandom;
            tick();
            n++;
            if (!done && P !== p_hold) p_changes++;
        end
        check("hs1_latency", 64'(n), 64'd33);
        check("hs1_P", P, ref_mul(a0, b0));
        check("hs_P_stable", 64'(p_changes), 64'd0);
        a1 = A;
        b1 = B;
        n = 0;
        tick();
        n++;
        check("hs2_busy_after_done", {63'b0, busy}, 64'd1);
        while (!done && n < 100) begin
            A = $urandom;
            B = $urandom;
            tick();
            n++;
        end
        start = 1'b0;
        check("hs2_spacing", 64'(n), 64'd34);
        check("hs2_P", P, ref_mul(a1, b1));
        tick();
        check("hs2_no_requeue", {63'b0, busy}, 64'd0);

        // Reset 10 cycles into CALC.
        A = 32'h1234_5678;
        B = 32'h9ABC_DEF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_P", P, 64'd0);
        run_op(32'hFFFF_FFF9, 32'd11, 64'hFFFF_FFFF_FFFF_FFB3, "post_rst");

        // Back-to-back random products.
        a0 = $urandom;
        b0 = $urandom;
        A = a0;
        B = b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            while (!done && n < 100) begin
                tick();
                n++;
            end
            if (!done) begin
                check("rand_timeout", 64'(n), 64'd34);
                break;
            end
            check($sformatf("rand%0d_spacing", i), 64'(n), (i == 0) ? 64'd33 : 64'd34);
            check($sformatf("rand%0d_P", i), P, ref_mul(a0, b0));
            if (i < 999) begin
                a0 = $urandom;
                b0 = $urandom;
                if (i % 97 == 5) a0 = 32'h8000_0000;
                if (i % 89 == 7) b0 = 32'd0;
                A = a0;
                B = b0;
                start = 1'b1;
                tick();
                start = 1'b0;
                A = $urandom;
                B = $urandom;
                n = 1;
            end
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
